// File: rtl/axis_packet_gen.sv
// axis_packet_gen: AXI4-Stream master that emits software-configured packets
// of incrementing data words, with tlast on the final beat of each packet and
// an optional idle gap between packets. Backpressure is fully honoured:
// nothing changes while tvalid is high and tready is low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no run active, tvalid low; waits for start with cfg_len != 0
// SEND  | tvalid high, presenting the data register as the current beat
// GAP   | tvalid low for cfg_gap cycles between packets (down-counter)

module axis_packet_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [15:0]           cfg_pkts,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [15:0]           pkts_q, pkts_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [15:0]           pkt_sent_q, pkt_sent_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  hs;
    logic                  last_pkt;

    assign hs = tvalid_q && m_axis_tready;

    // Run ends after this packet when the packet quota is reached or a stop
    // is pending (including a stop arriving on the tlast handshake itself).
    assign last_pkt = ((pkts_q != 16'd0) && ((pkt_sent_q + 16'd1) == pkts_q))
                      || stop_pend_q || stop;

    // State register and all output flops; synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pkts_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            data_q      <= '0;
            beat_q      <= '0;
            pkt_sent_q  <= '0;
            stop_pend_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pkts_q      <= pkts_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            data_q      <= data_d;
            beat_q      <= beat_d;
            pkt_sent_q  <= pkt_sent_d;
            stop_pend_q <= stop_pend_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so that
    // every output leaves the design straight from a flop.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pkts_d      = pkts_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        data_d      = data_q;
        beat_d      = beat_q;
        pkt_sent_d  = pkt_sent_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;

        if (stop && (state_q != IDLE)) begin
            stop_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start && (cfg_len != '0)) begin
                    len_d      = cfg_len;
                    pkts_d     = cfg_pkts;
                    gap_d      = cfg_gap;
                    data_d     = cfg_seed;
                    beat_d     = '0;
                    pkt_sent_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    data_d = data_q + 1'b1;
                    if (tlast_q) begin
                        beat_d     = '0;
                        pkt_sent_d = pkt_sent_q + 16'd1;
                        if (last_pkt) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop || stop_pend_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
        end

        tvalid_d = (state_d == SEND);
        busy_d   = (state_d != IDLE);
        tlast_d  = (state_d == SEND) && (beat_d == (len_d - LEN_WIDTH'(1)));
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_sent      = pkt_sent_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed bench for axis_packet_gen: reset, fixed run, backpressure,
// gap with data wrap, stop handling and reset mid-packet.
`timescale 1ns/1ps

module tb_axis_packet_gen;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        stop;
    logic [15:0] cfg_len;
    logic [15:0] cfg_pkts;
    logic [7:0]  cfg_gap;
    logic [31:0] cfg_seed;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [15:0] pkt_sent;

    int checks = 0;
    int errors = 0;

    axis_packet_gen #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (16),
        .GAP_WIDTH (8)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .start        (start),
        .stop         (stop),
        .cfg_len      (cfg_len),
        .cfg_pkts     (cfg_pkts),
        .cfg_gap      (cfg_gap),
        .cfg_seed     (cfg_seed),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .pkt_sent     (pkt_sent)
    );

    // 100 MHz clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; return at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] pkts,
                            input logic [7:0] gap, input logic [31:0] seed);
        cfg_len  = len;
        cfg_pkts = pkts;
        cfg_gap  = gap;
        cfg_seed = seed;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    logic [31:0] exp_d;
    int          k;
    logic        bp_pat [6];
    logic        gw_v   [8];
    logic [31:0] gw_d   [8];
    logic        gw_l   [8];

    initial begin
        aresetn       = 1'b0;
        start         = 1'b1;
        stop          = 1'b0;
        m_axis_tready = 1'b1;
        cfg_len       = 16'd4;
        cfg_pkts      = 16'd1;
        cfg_gap       = 8'd0;
        cfg_seed      = 32'hDEAD_BEEF;

        // Reset held 5 cycles with start asserted and tready high
        @(negedge aclk);
        for (int i = 0; i < 5; i++) begin
            chk("reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
            tick();
        end
        chk("reset_tdata",    {32'd0, m_axis_tdata}, 64'd0);
        chk("reset_tlast",    {63'd0, m_axis_tlast}, 64'd0);
        chk("reset_busy",     {63'd0, busy}, 64'd0);
        chk("reset_done",     {63'd0, done}, 64'd0);
        chk("reset_pkt_sent", {48'd0, pkt_sent}, 64'd0);
        start   = 1'b0;
        aresetn = 1'b1;
        tick();
        chk("idle_tvalid", {63'd0, m_axis_tvalid}, 64'd0);

        // start with cfg_len == 0 is ignored
        do_start(16'd0, 16'd1, 8'd0, 32'h5);
        chk("len0_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("len0_busy",   {63'd0, busy}, 64'd0);
        tick();
        chk("len0_done",   {63'd0, done}, 64'd0);

        // Fixed run: len 4, 2 packets, no gap; a start mid-run is ignored
        do_start(16'd4, 16'd2, 8'd0, 32'h10);
        for (int i = 0; i < 8; i++) begin
            chk("fix_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
            chk("fix_busy",   {63'd0, busy}, 64'd1);
            chk("fix_tdata",  {32'd0, m_axis_tdata}, 64'h10 + 64'(i));
            chk("fix_tlast",  {63'd0, m_axis_tlast}, ((i % 4) == 3) ? 64'd1 : 64'd0);
            start    = (i == 2);
            cfg_seed = 32'h999;
            tick();
        end
        start = 1'b0;
        chk("fix_end_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("fix_end_done",   {63'd0, done}, 64'd1);
        chk("fix_end_busy",   {63'd0, busy}, 64'd0);
        chk("fix_pkt_sent",   {48'd0, pkt_sent}, 64'd2);
        tick();
        chk("fix_done_1cyc",  {63'd0, done}, 64'd0);

        // Backpressure: len 3, tready pattern 1,0,0,1,0,1
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_start(16'd3, 16'd1, 8'd0, 32'h0);
        chk("bp_pkt_sent_clr", {48'd0, pkt_sent}, 64'd0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = bp_pat[i];
            chk("bp_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
            chk("bp_tdata",  {32'd0, m_axis_tdata}, 64'(k));
            chk("bp_tlast",  {63'd0, m_axis_tlast}, (k == 2) ? 64'd1 : 64'd0);
            tick();
            if (bp_pat[i]) k++;
        end
        m_axis_tready = 1'b1;
        chk("bp_done",     {63'd0, done}, 64'd1);
        chk("bp_tvalid_0", {63'd0, m_axis_tvalid}, 64'd0);
        chk("bp_pkt_sent", {48'd0, pkt_sent}, 64'd1);

        // Gap and wrap: len 2, 2 packets, gap 3, seed all-ones
        gw_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        gw_d = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h2, 32'h0};
        gw_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_start(16'd2, 16'd2, 8'd3, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            chk("gw_tvalid", {63'd0, m_axis_tvalid}, {63'd0, gw_v[i]});
            if (gw_v[i]) begin
                chk("gw_tdata", {32'd0, m_axis_tdata}, {32'd0, gw_d[i]});
                chk("gw_tlast", {63'd0, m_axis_tlast}, {63'd0, gw_l[i]});
            end
            if (i >= 2 && i <= 4) begin
                chk("gw_busy", {63'd0, busy}, 64'd1);
            end
            if (i < 7) tick();
        end
        chk("gw_done",     {63'd0, done}, 64'd1);
        chk("gw_pkt_sent", {48'd0, pkt_sent}, 64'd2);
        tick();

        // Stop in continuous mode on the 3rd handshake: packet still completes
        do_start(16'd8, 16'd0, 8'd0, 32'h20);
        for (int i = 0; i < 8; i++) begin
            chk("stop_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
            chk("stop_tdata",  {32'd0, m_axis_tdata}, 64'h20 + 64'(i));
            chk("stop_tlast",  {63'd0, m_axis_tlast}, (i == 7) ? 64'd1 : 64'd0);
            stop = (i == 2);
            tick();
        end
        stop = 1'b0;
        chk("stop_end_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("stop_done",       {63'd0, done}, 64'd1);
        chk("stop_busy",       {63'd0, busy}, 64'd0);
        chk("stop_pkt_sent",   {48'd0, pkt_sent}, 64'd1);
        tick();

        // stop coincident with the tlast handshake
        do_start(16'd2, 16'd0, 8'd2, 32'h40);
        exp_d = 32'h40;
        for (int i = 0; i < 2; i++) begin
            chk("stl_tdata", {32'd0, m_axis_tdata}, {32'd0, exp_d});
            stop = (i == 1);
            tick();
            exp_d = exp_d + 32'd1;
        end
        stop = 1'b0;
        chk("stl_done",     {63'd0, done}, 64'd1);
        chk("stl_busy",     {63'd0, busy}, 64'd0);
        chk("stl_pkt_sent", {48'd0, pkt_sent}, 64'd1);
        tick();

        // stop during GAP forces IDLE the next cycle
        do_start(16'd2, 16'd0, 8'd4, 32'h50);
        tick();
        tick();
        chk("sgap_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("sgap_busy",   {63'd0, busy}, 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("sgap_done",     {63'd0, done}, 64'd1);
        chk("sgap_busy_0",   {63'd0, busy}, 64'd0);
        chk("sgap_tvalid_0", {63'd0, m_axis_tvalid}, 64'd0);
        tick();
        chk("sgap_idle",     {63'd0, m_axis_tvalid}, 64'd0);

        // Reset mid-packet after 2 beats of a len-6 packet
        do_start(16'd6, 16'd0, 8'd0, 32'h80);
        chk("rst_b0", {32'd0, m_axis_tdata}, 64'h80);
        tick();
        chk("rst_b1", {32'd0, m_axis_tdata}, 64'h81);
        tick();
        aresetn = 1'b0;
        tick();
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        aresetn = 1'b1;
        tick();
        chk("rst_done_after", {63'd0, done}, 64'd0);
        do_start(16'd2, 16'd1, 8'd0, 32'h100);
        chk("rst_new_tdata",    {32'd0, m_axis_tdata}, 64'h100);
        chk("rst_new_pkt_sent", {48'd0, pkt_sent}, 64'd0);
        tick();
        chk("rst_new_tdata1",   {32'd0, m_axis_tdata}, 64'h101);
        chk("rst_new_tlast",    {63'd0, m_axis_tlast}, 64'd1);
        tick();
        chk("rst_new_done",     {63'd0, done}, 64'd1);
        chk("rst_new_pkt_sent1", {48'd0, pkt_sent}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
